// File: rtl/insn_queue_pkg.sv
// Shared widths for the instruction queue and the entry type stored in it.
// The define block below is the guarded shared-widths section used by every pipeline stage.
`ifndef CPU_DEFINES_SVH
`define CPU_DEFINES_SVH
`define PC_WIDTH     32
`define WORD_WIDTH   32
`define IQ_DEPTH     8
`define IQ_PTR_WIDTH 3
`endif

package insn_queue_pkg;

    localparam int PC_W   = `PC_WIDTH;
    localparam int WORD_W = `WORD_WIDTH;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [WORD_W-1:0] insn;
    } iq_entry_t;

    // Dequeue request of 3 behaves as 2; result never exceeds what is available.
    function automatic logic [1:0] clamp_deq(input logic [1:0] req, input logic [1:0] avail);
        logic [1:0] req_sat;
        req_sat = (req == 2'd3) ? 2'd2 : req;
        return (req_sat < avail) ? req_sat : avail;
    endfunction

endpackage

// File: rtl/insn_queue_mem.sv
// Entry storage for the instruction queue: one write port, two asynchronous read ports.
// Data is never reset; validity is tracked by the pointer/count logic in the parent.
module insn_queue_mem
    import insn_queue_pkg::*;
#(
    parameter int DEPTH = `IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  iq_entry_t        wr_data,
    input  logic [PTR_W-1:0] rd_addr0,
    output iq_entry_t        rd_data0,
    input  logic [PTR_W-1:0] rd_addr1,
    output iq_entry_t        rd_data1
);

    iq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data0 = mem_q[rd_addr0];
    assign rd_data1 = mem_q[rd_addr1];

endmodule

// File: rtl/insn_queue.sv
// Instruction queue between fetch and decode: circular FIFO with one enqueue and up
// to two in-order dequeues per cycle, fetch back-pressure and a full flush.
module insn_queue
    import insn_queue_pkg::*;
#(
    parameter int DEPTH = `IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_en,
    input  logic              iq_flush,
    input  logic              in_en,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [WORD_W-1:0] in_insn,
    output logic              iq_stall,
    output logic              iq_valid0,
    output logic              iq_valid1,
    output logic [PC_W-1:0]   iq_pc0,
    output logic [PC_W-1:0]   iq_pc1,
    output logic [WORD_W-1:0] iq_insn0,
    output logic [WORD_W-1:0] iq_insn1,
    input  logic [1:0]        id_deq
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [1:0] deq_avail;
    logic [1:0] deq_eff;
    logic       full;
    logic       enq;
    iq_entry_t  rd0, rd1;

    assign deq_avail = (count_q >= (PTR_W+1)'(2)) ? 2'd2 : count_q[1:0];
    assign deq_eff   = clamp_deq(id_deq, deq_avail);
    assign full      = (count_q == (PTR_W+1)'(DEPTH));

    // A full queue still accepts when decode frees a slot in the same cycle.
    assign enq      = cpu_en & in_en & ~iq_flush & (~full | (deq_eff != 2'd0));
    assign iq_stall = full & (deq_eff == 2'd0) & ~iq_flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (cpu_en) begin
            if (iq_flush) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                head_d  = head_q + PTR_W'(deq_eff);
                tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
                count_d = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(deq_eff);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    insn_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk      (clk),
        .wr_en    (enq),
        .wr_addr  (tail_q),
        .wr_data  ('{pc: in_pc, insn: in_insn}),
        .rd_addr0 (head_q),
        .rd_data0 (rd0),
        .rd_addr1 (head_q + PTR_W'(1)),
        .rd_data1 (rd1)
    );

    // Outputs depend only on registered state, so id_deq reaches nothing but iq_stall.
    assign iq_valid0 = (count_q != '0);
    assign iq_valid1 = (count_q >= (PTR_W+1)'(2));
    assign iq_pc0    = iq_valid0 ? rd0.pc   : '0;
    assign iq_insn0  = iq_valid0 ? rd0.insn : '0;
    assign iq_pc1    = iq_valid1 ? rd1.pc   : '0;
    assign iq_insn1  = iq_valid1 ? rd1.insn : '0;

endmodule

// File: tb/tb_insn_queue.sv
// Bench for insn_queue: a vector table for fill/full/flush, then hand sequences for
// wrap, clamp, cpu_en gating and asynchronous reset, all against a queue model.
module tb_insn_queue;
    import insn_queue_pkg::*;

    localparam int DEPTH = `IQ_DEPTH;
    localparam int EW    = PC_W + WORD_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_en = 1'b0;
    logic              iq_flush = 1'b0;
    logic              in_en = 1'b0;
    logic [PC_W-1:0]   in_pc = '0;
    logic [WORD_W-1:0] in_insn = '0;
    logic [1:0]        id_deq = '0;
    logic              iq_stall, iq_valid0, iq_valid1;
    logic [PC_W-1:0]   iq_pc0, iq_pc1;
    logic [WORD_W-1:0] iq_insn0, iq_insn1;

    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic            ce;
        logic            fl;
        logic            ie;
        logic [1:0]      dq;
        logic [PC_W-1:0] pc;
        logic            exp_stall;
        int              exp_count;
    } vec_t;
    vec_t vecs[$];

    insn_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_en    (cpu_en),
        .iq_flush  (iq_flush),
        .in_en     (in_en),
        .in_pc     (in_pc),
        .in_insn   (in_insn),
        .iq_stall  (iq_stall),
        .iq_valid0 (iq_valid0),
        .iq_valid1 (iq_valid1),
        .iq_pc0    (iq_pc0),
        .iq_pc1    (iq_pc1),
        .iq_insn0  (iq_insn0),
        .iq_insn1  (iq_insn1),
        .id_deq    (id_deq)
    );

    always #5 clk = ~clk;

    function automatic logic [WORD_W-1:0] insn_of(input logic [PC_W-1:0] pc);
        logic [31:0] w;
        w = {pc[15:0] ^ 16'hC0DE, pc[15:0]};
        return WORD_W'(w);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag);
        logic [EW-1:0] e0, e1;
        e0 = '0;
        e1 = '0;
        if (exp_q.size() >= 1) e0 = exp_q[0];
        if (exp_q.size() >= 2) e1 = exp_q[1];
        check({tag, ".valid0"}, 64'(iq_valid0), 64'(exp_q.size() >= 1));
        check({tag, ".valid1"}, 64'(iq_valid1), 64'(exp_q.size() >= 2));
        check({tag, ".pc0"},    64'(iq_pc0),    64'(e0[EW-1 -: PC_W]));
        check({tag, ".insn0"},  64'(iq_insn0),  64'(e0[WORD_W-1:0]));
        check({tag, ".pc1"},    64'(iq_pc1),    64'(e1[EW-1 -: PC_W]));
        check({tag, ".insn1"},  64'(iq_insn1),  64'(e1[WORD_W-1:0]));
        check({tag, ".count"},  64'(dut.count_q), 64'(exp_q.size()));
    endtask

    // Drive one cycle, check pre-edge outputs against the model, update the model, cross the edge.
    task automatic drive_cycle(input logic ce, input logic fl, input logic ie,
                               input logic [PC_W-1:0] pc, input logic [1:0] dq,
                               output logic acc, output logic st_act);
        int   cnt, d;
        logic full_m, exp_st;
        cpu_en   = ce;
        iq_flush = fl;
        in_en    = ie;
        in_pc    = pc;
        in_insn  = insn_of(pc);
        id_deq   = dq;
        #1;
        cnt    = exp_q.size();
        d      = (dq == 2'd3) ? 2 : int'(dq);
        if (d > cnt) d = cnt;
        full_m = (cnt == DEPTH);
        exp_st = full_m && (d == 0) && !fl;
        st_act = iq_stall;
        check("stall", 64'(iq_stall), 64'(exp_st));
        check_outs("pre");
        acc = 1'b0;
        if (ce) begin
            if (fl) begin
                exp_q.delete();
            end else begin
                repeat (d) void'(exp_q.pop_front());
                if (ie && (!full_m || d != 0)) begin
                    exp_q.push_back({pc, insn_of(pc)});
                    acc = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc, st;
        int   sent;
        logic saw_wrap;

        for (int i = 0; i < 8; i++) vecs.push_back('{1, 0, 1, 2'd0, PC_W'(i * 4), 0, i + 1});
        vecs.push_back('{1, 0, 1, 2'd0, PC_W'('h20), 1, 8});
        vecs.push_back('{1, 0, 1, 2'd0, PC_W'('h20), 1, 8});
        vecs.push_back('{1, 0, 1, 2'd1, PC_W'('h20), 0, 8});
        vecs.push_back('{1, 0, 0, 2'd2, PC_W'('h20), 0, 6});
        vecs.push_back('{1, 0, 0, 2'd0, PC_W'(0),    0, 6});
        vecs.push_back('{1, 0, 0, 2'd1, PC_W'(0),    0, 5});
        vecs.push_back('{1, 1, 1, 2'd2, PC_W'('h99), 0, 0});
        vecs.push_back('{1, 0, 0, 2'd0, PC_W'(0),    0, 0});

        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", 64'(iq_stall), 64'(0));
        check_outs("reset");
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            drive_cycle(vecs[k].ce, vecs[k].fl, vecs[k].ie, vecs[k].pc, vecs[k].dq, acc, st);
            check($sformatf("tbl%0d.stall", k), 64'(st), 64'(vecs[k].exp_stall));
            check($sformatf("tbl%0d.count", k), 64'(dut.count_q), 64'(vecs[k].exp_count));
            if (k == 10) check("full_deq.pc0", 64'(iq_pc0), 64'('h04));
        end

        sent     = 0;
        saw_wrap = 1'b0;
        for (int c = 0; c < 100 && (sent < 16 || exp_q.size() != 0); c++) begin
            logic [1:0] dq;
            dq = (c == 3) ? 2'd1 : ((c >= 4 && c % 2 == 1) ? 2'd2 : 2'd0);
            if (sent >= 16) dq = 2'd2;
            if (dut.head_q == 3'd7 && iq_valid1) begin
                check("wrap_pc1", 64'(iq_pc1), 64'(exp_q[1][EW-1 -: PC_W]));
                saw_wrap = 1'b1;
            end
            drive_cycle(1, 0, sent < 16, PC_W'(sent * 4), dq, acc, st);
            if (acc) sent++;
        end
        check("wrap_sent", 64'(sent), 64'(16));
        check("wrap_seen", 64'(saw_wrap), 64'(1));

        drive_cycle(1, 0, 1, PC_W'('h100), 2'd0, acc, st);
        drive_cycle(1, 0, 0, PC_W'(0), 2'd2, acc, st);
        check("clamp.count", 64'(dut.count_q), 64'(0));
        check("clamp.valid0", 64'(iq_valid0), 64'(0));
        check("clamp.pc0", 64'(iq_pc0), 64'(0));

        drive_cycle(1, 0, 1, PC_W'('h104), 2'd2, acc, st);
        check("empty_deq2.count", 64'(dut.count_q), 64'(1));
        check("empty_deq2.pc0", 64'(iq_pc0), 64'('h104));

        drive_cycle(1, 0, 1, PC_W'('h108), 2'd0, acc, st);
        drive_cycle(1, 0, 1, PC_W'('h10C), 2'd0, acc, st);
        for (int c = 0; c < 3; c++) drive_cycle(0, 0, 1, PC_W'('h200), 2'd2, acc, st);
        check("gate.count", 64'(dut.count_q), 64'(3));
        check("gate.pc0", 64'(iq_pc0), 64'('h104));
        check("gate.pc1", 64'(iq_pc1), 64'('h108));

        rst_n = 1'b0;
        #1;
        check("async_rst.valid0", 64'(iq_valid0), 64'(0));
        check("async_rst.valid1", 64'(iq_valid1), 64'(0));
        check("async_rst.pc0", 64'(iq_pc0), 64'(0));
        check("async_rst.insn0", 64'(iq_insn0), 64'(0));
        check("async_rst.stall", 64'(iq_stall), 64'(0));
        check("async_rst.count", 64'(dut.count_q), 64'(0));
        exp_q.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_cycle(1, 0, 1, PC_W'('h300), 2'd0, acc, st);
        check("post_rst.count", 64'(dut.count_q), 64'(1));
        check("post_rst.pc0", 64'(iq_pc0), 64'('h300));
        check_outs("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/insn_queue.md
# insn_queue

Instruction queue between the IF pipeline register and decode/dispatch. Buffers fetched (pc, insn) pairs in a circular FIFO and accepts one entry per cycle. Presents up to two in-order head entries to decode, and decode retires 0, 1 or 2 of them per cycle. Back-pressures fetch through a stall request, and discards all contents on a pipeline flush.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥ 4
- PTR_W, $clog2(DEPTH), head/tail pointer width
- Data widths come from the shared `PC_WIDTH` / `WORD_WIDTH` macros.

Ports:
- clk  in  1  single clock; all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_en  in  1  global enable; when 0, no state changes
- iq_flush  in  1  discard all entries (redirect/exception)
- in_en  in  1  upstream entry valid (from IF register enable)
- in_pc  in  PC_WIDTH  upstream pc
- in_insn  in  WORD_WIDTH  upstream instruction
- iq_stall  out  1  stall request to IF (combinational)
- iq_valid0 / iq_valid1  out  1  head / head+1 entry valid
- iq_pc0 / iq_pc1  out  PC_WIDTH  head / head+1 pc
- iq_insn0 / iq_insn1  out  WORD_WIDTH  head / head+1 insn
- id_deq  in  2  entries consumed by decode this cycle (0..2)

## Operation
- State: storage array of DEPTH × {pc, insn}, head and tail pointers (PTR_W bits, wrap modulo DEPTH), and count (PTR_W+1 bits, 0..DEPTH).
- deq_eff = min(id_deq, count). Requests beyond the valid entries are clamped. A value of 3 is treated as 2, then clamped.
- full = (count == DEPTH).
- enq = cpu_en & in_en & !iq_flush & (!full | deq_eff != 0).
- iq_stall = full & (deq_eff == 0). It is independent of cpu_en and low whenever iq_flush = 1.
- On enq, write {in_pc, in_insn} at tail, then tail += 1.
- On dequeue (cpu_en & !iq_flush), head += deq_eff.
- Count update: count += enq − deq_eff.
- Flush has priority over enqueue and dequeue in the same cycle. Next cycle: head = tail = count = 0. Array contents are don't-care.
- cpu_en = 0 holds all state. Outputs still reflect the current contents.
- Outputs:
  - iq_valid0 = (count ≥ 1); iq_valid1 = (count ≥ 2).
  - pc/insn outputs read head and head+1 (mod DEPTH).
  - When the matching valid bit is 0, pc/insn outputs are forced to 0.
- Upstream holds in_en, in_pc and in_insn stable while iq_stall = 1, so no entry is lost. The queue never drops an entry for which enq = 0.

## Timing
- Reset: all outputs 0 (iq_valid*, iq_pc*, iq_insn*, iq_stall); head = tail = count = 0.
- Enqueue-to-visible latency is 1 cycle: an entry written at edge N is on iq_*0 after edge N if the queue was empty. There is no same-cycle bypass.
- Dequeue takes effect at the edge. The new head is presented in the following cycle.
- Full with deq_eff > 0: the enqueue is accepted in the same cycle, count stays DEPTH (for deq 1) or drops to DEPTH−1 (for deq 2), and iq_stall = 0.
- Empty with id_deq = 2 and enq: deq_eff = 0, count becomes 1.
- Pointer wrap: tail at DEPTH−1 enqueues, then tail = 0. iq_pc1 wraps to index 0 when head = DEPTH−1.
- Reset asserted mid-operation clears immediately (async). The first enqueue is accepted on the first edge after release.
- Combinational path id_deq → iq_stall is allowed. It must be the only path from id_deq to outputs.

## Structure
- Add `IQ_DEPTH` and `IQ_PTR_WIDTH` to the shared define file next to `PC_WIDTH` / `WORD_WIDTH`. Users include that file, with the same include guard convention as the other stages.
- One sub-module is natural: `insn_queue_mem`, a 1-write / 2-read register array.
  - Write port: en, addr, {pc, insn}.
  - Two async read ports.
  - No reset on data.
- Pointer, count, stall and valid logic live in `insn_queue`.

## Test plan
- Reset then fill: enqueue pc 0x00,0x04,…,0x1C with id_deq = 0.
  - After the 8th accept, iq_stall = 1 and count = 8.
  - A 9th held entry (pc 0x20) is not written.
  - iq_pc0 = 0x00, iq_pc1 = 0x04.
- Full plus dequeue: with queue full and pc 0x20 held, set id_deq = 1.
  - iq_stall = 0 that cycle and 0x20 is accepted.
  - Next cycle: iq_pc0 = 0x04, count = 8.
- Dual dequeue and wrap: cycle 16 entries through with id_deq = 2 every other cycle.
  - Output order is strictly 0x00…0x3C.
  - iq_pc1 is correct when head = 7 (reads index 0).
- Clamp: count = 1, id_deq = 2, no enqueue → count = 0, iq_valid0 = 0, iq_pc0 = 0.
- Flush priority: count = 5, assert iq_flush together with in_en = 1 and id_deq = 2.
  - Next cycle: count = 0, all valid = 0, iq_stall = 0, and the in_en entry is not stored.
- cpu_en gating and async reset: with cpu_en = 0, in_en = 1 and id_deq = 2 for 3 cycles, count is unchanged.
  - Asserting rst_n = 0 mid-cycle zeroes outputs before the next edge.
